// File: rtl/regfile_write_arbiter.sv
// Two-producer write-back arbiter: ALU and load requests are queued in order
// and drained into the register file's single write port at one write per cycle.
module regfile_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_reg,
    input  logic [31:0]              mem_data,
    output logic                     RegWrite,
    output logic [4:0]               Write_register,
    output logic [31:0]              Write_data,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [4:0]               query_reg,
    output logic                     query_hit
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: a request transfers on a rising edge where its valid and
    // ready are both high; ready never depends on the same producer's valid.
    logic [4:0]    ent_reg_q  [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en_q;
    logic [4:0]    wr_reg_q;
    logic [31:0]   wr_data_q;

    logic [CW-1:0] free;
    logic          pop;
    logic          push_mem;
    logic          push_alu;
    logic [PW-1:0] alu_slot;

    assign free      = CW'(DEPTH) - count_q;
    assign pop       = (count_q != '0);
    assign mem_ready = (free != '0);
    assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);

    // Writes to r0 finish the handshake but are dropped here.
    assign push_mem  = mem_valid && mem_ready && (mem_reg != 5'd0);
    assign push_alu  = alu_valid && alu_ready && (alu_reg != 5'd0);
    assign alu_slot  = tail_q + PW'(push_mem);

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push_mem) + PW'(push_alu);
        count_d = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wr_en_q <= pop;
            if (pop) begin
                wr_reg_q  <= ent_reg_q[head_q];
                wr_data_q <= ent_data_q[head_q];
            end
        end
    end

    // Entry storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push_mem) begin
            ent_reg_q[tail_q]  <= mem_reg;
            ent_data_q[tail_q] <= mem_data;
        end
        if (push_alu) begin
            ent_reg_q[alu_slot]  <= alu_reg;
            ent_data_q[alu_slot] <= alu_data;
        end
    end

    always_comb begin
        query_hit = wr_en_q && (wr_reg_q == query_reg);
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (ent_reg_q[head_q + PW'(k)] == query_reg)) begin
                query_hit = 1'b1;
            end
        end
        if (query_reg == 5'd0) begin
            query_hit = 1'b0;
        end
    end

    assign RegWrite       = wr_en_q;
    assign Write_register = wr_reg_q;
    assign Write_data     = wr_data_q;
    assign count          = count_q;
endmodule
